// File: rtl/dma_priority_arbiter_pkg.sv
// dmaRegConfigPkg: shared channel count and arbiter FSM state encoding.
package dmaRegConfigPkg;

    localparam int CHANNELS = 4;

    typedef enum logic [1:0] {
        IDLE,
        HOLD_REQ,
        GRANTED,
        RELEASE
    } arb_state_t;

endpackage

// File: rtl/dma_priority_arbiter_rotate_pick.sv
// dma_rotate_pick: picks the first requesting channel at or after the highest-priority index, wrapping.
module dma_rotate_pick #(
    parameter int CHANNELS = 4,
    parameter int CW = 2
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [CW-1:0]       high,
    output logic [CW-1:0]       winner
);

    logic [CW:0]   sum;
    logic [CW-1:0] idx;

    // Scan from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        winner = high;
        sum = '0;
        idx = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            sum = {1'b0, high} + (CW+1)'(k);
            idx = CW'(sum >= (CW+1)'(CHANNELS) ? sum - (CW+1)'(CHANNELS) : sum);
            if (req[idx]) winner = idx;
        end
    end

endmodule

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: 8237-style DMA channel arbiter with hold request/acknowledge handshake
// and fixed or rotating priority.
module dma_priority_arbiter
    import dmaRegConfigPkg::*;
#(
    parameter int CHANNELS = dmaRegConfigPkg::CHANNELS
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [CHANNELS-1:0]         DREQ,
    input  logic                        HLDA,
    input  logic [CHANNELS-1:0]         mask,
    input  logic [CHANNELS-1:0]         swReq,
    input  logic                        ctrlDisable,
    input  logic                        rotPriority,
    input  logic                        dreqSenseLow,
    input  logic                        dackSenseHigh,
    input  logic                        xferDone,
    output logic                        HRQ,
    output logic [CHANNELS-1:0]         DACK,
    output logic [$clog2(CHANNELS)-1:0] activeCh,
    output logic                        chValid,
    output logic [CHANNELS-1:0]         swReqClr
);

    localparam int CW = $clog2(CHANNELS);

    arb_state_t          state, state_n;
    logic [CHANNELS-1:0] dreq_q;
    logic [CHANNELS-1:0] eff_req;
    logic [CHANNELS-1:0] grant;
    logic [CW-1:0]       last_served;
    logic [CW-1:0]       high;
    logic [CW-1:0]       winner;
    logic                load;
    logic                done;

    assign eff_req = ((dreq_q ^ {CHANNELS{dreqSenseLow}}) & ~mask) | swReq;
    assign high    = rotPriority ? (last_served == CW'(CHANNELS - 1) ? '0 : last_served + 1'b1) : '0;
    assign chValid = state == GRANTED;
    assign grant   = chValid ? CHANNELS'(1) << activeCh : '0;
    assign DACK    = grant ^ {CHANNELS{~dackSenseHigh}};

    dma_rotate_pick #(
        .CHANNELS (CHANNELS),
        .CW       (CW)
    ) u_pick (
        .req    (eff_req),
        .high   (high),
        .winner (winner)
    );

    always_comb begin
        state_n = state;
        load = 1'b0;
        done = 1'b0;
        unique case (state)
            IDLE:     if (!ctrlDisable && |eff_req) state_n = HOLD_REQ;
            HOLD_REQ: begin
                if (ctrlDisable || ~|eff_req) state_n = IDLE;
                else if (HLDA) begin
                    state_n = GRANTED;
                    load = 1'b1;
                end
            end
            // Losing HLDA aborts the service without crediting the channel as served.
            GRANTED:  begin
                if (!HLDA) state_n = IDLE;
                else if (xferDone) begin
                    state_n = RELEASE;
                    done = 1'b1;
                end
            end
            RELEASE:  if (!HLDA) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            HRQ         <= 1'b0;
            dreq_q      <= '0;
            activeCh    <= '0;
            last_served <= CW'(CHANNELS - 1);
            swReqClr    <= '0;
        end else begin
            state    <= state_n;
            HRQ      <= state_n == HOLD_REQ || state_n == GRANTED;
            dreq_q   <= DREQ;
            swReqClr <= done ? CHANNELS'(1) << activeCh : '0;
            if (load) activeCh <= winner;
            if (done) last_served <= activeCh;
        end
    end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// tb_dma_priority_arbiter: scenario tasks with a queue of expected grant channels.
module tb_dma_priority_arbiter;

    logic       CLK;
    logic       RESET;
    logic [3:0] DREQ;
    logic       HLDA;
    logic [3:0] mask;
    logic [3:0] swReq;
    logic       ctrlDisable;
    logic       rotPriority;
    logic       dreqSenseLow;
    logic       dackSenseHigh;
    logic       xferDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic [1:0] activeCh;
    logic       chValid;
    logic [3:0] swReqClr;

    int total = 0;
    int bad = 0;
    int exp_q[$];

    dma_priority_arbiter dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .DREQ          (DREQ),
        .HLDA          (HLDA),
        .mask          (mask),
        .swReq         (swReq),
        .ctrlDisable   (ctrlDisable),
        .rotPriority   (rotPriority),
        .dreqSenseLow  (dreqSenseLow),
        .dackSenseHigh (dackSenseHigh),
        .xferDone      (xferDone),
        .HRQ           (HRQ),
        .DACK          (DACK),
        .activeCh      (activeCh),
        .chValid       (chValid),
        .swReqClr      (swReqClr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        DREQ = '0;
        HLDA = 1'b0;
        mask = '0;
        swReq = '0;
        ctrlDisable = 1'b0;
        rotPriority = 1'b0;
        dreqSenseLow = 1'b0;
        dackSenseHigh = 1'b0;
        xferDone = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
        tick();
    endtask

    task automatic wait_hrq(output bit to);
        for (int i = 0; i < 20 && HRQ !== 1'b1; i++) tick();
        to = HRQ !== 1'b1;
    endtask

    task automatic wait_valid(output bit to);
        for (int i = 0; i < 20 && chValid !== 1'b1; i++) tick();
        to = chValid !== 1'b1;
    endtask

    task automatic pulse_done();
        xferDone = 1'b1;
        tick();
        xferDone = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        RESET = 1'b0;
        tick();
        total += 5;
        if (HRQ !== 1'b0) begin bad++; $display("FAIL reset_hrq got=%b want=0", HRQ); end
        if (DACK !== 4'hF) begin bad++; $display("FAIL reset_dack_lo got=%b want=1111", DACK); end
        if (chValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", chValid); end
        if (activeCh !== 2'd0) begin bad++; $display("FAIL reset_active got=%0d want=0", activeCh); end
        if (swReqClr !== 4'h0) begin bad++; $display("FAIL reset_swclr got=%b want=0000", swReqClr); end
        dackSenseHigh = 1'b1;
        #1;
        total++;
        if (DACK !== 4'h0) begin bad++; $display("FAIL reset_dack_hi got=%b want=0000", DACK); end
        RESET = 1'b1;
        tick();
    endtask

    task automatic test_fixed();
        bit to;
        int e;
        do_reset();
        DREQ = 4'b0110;
        exp_q.push_back(1);
        wait_hrq(to);
        total++;
        if (to) begin bad++; $display("FAIL fixed_hrq timeout got=%b want=1", HRQ); end
        tick();
        tick();
        HLDA = 1'b1;
        wait_valid(to);
        e = exp_q.pop_front();
        total += 3;
        if (to) begin bad++; $display("FAIL fixed_grant timeout got=%b want=1", chValid); end
        if (activeCh !== 2'(e)) begin bad++; $display("FAIL fixed_active got=%0d want=%0d", activeCh, e); end
        if (DACK !== 4'b1101) begin bad++; $display("FAIL fixed_dack got=%b want=1101", DACK); end
        DREQ = '0;
        pulse_done();
        total += 2;
        if (HRQ !== 1'b0) begin bad++; $display("FAIL fixed_rel_hrq got=%b want=0", HRQ); end
        if (DACK !== 4'hF) begin bad++; $display("FAIL fixed_rel_dack got=%b want=1111", DACK); end
        HLDA = 1'b0;
        tick();
    endtask

    task automatic test_rotating();
        bit to;
        int e;
        do_reset();
        rotPriority = 1'b1;
        DREQ = 4'b1111;
        for (int c = 0; c < 4; c++) exp_q.push_back(c);
        for (int n = 0; n < 4; n++) begin
            wait_hrq(to);
            HLDA = 1'b1;
            wait_valid(to);
            e = exp_q.pop_front();
            total++;
            if (to || activeCh !== 2'(e)) begin
                bad++;
                $display("FAIL rot_grant%0d got=%0d valid=%b want=%0d", n, activeCh, chValid, e);
            end
            pulse_done();
            HLDA = 1'b0;
            tick();
        end
        DREQ = '0;
        tick();
        tick();
    endtask

    task automatic test_mask_sw();
        bit to;
        int e;
        do_reset();
        dackSenseHigh = 1'b1;
        DREQ = 4'b0001;
        mask = 4'b0001;
        swReq = 4'b1000;
        exp_q.push_back(3);
        wait_hrq(to);
        HLDA = 1'b1;
        wait_valid(to);
        e = exp_q.pop_front();
        total += 2;
        if (to || activeCh !== 2'(e)) begin bad++; $display("FAIL sw_active got=%0d want=%0d", activeCh, e); end
        if (DACK !== 4'b1000) begin bad++; $display("FAIL sw_dack got=%b want=1000", DACK); end
        pulse_done();
        total += 2;
        if (swReqClr !== 4'b1000) begin bad++; $display("FAIL sw_clr got=%b want=1000", swReqClr); end
        if (HRQ !== 1'b0) begin bad++; $display("FAIL sw_hrq got=%b want=0", HRQ); end
        swReq = '0;
        tick();
        total++;
        if (swReqClr !== 4'b0000) begin bad++; $display("FAIL sw_clr_end got=%b want=0000", swReqClr); end
        HLDA = 1'b0;
        tick();
    endtask

    task automatic test_withdraw();
        do_reset();
        DREQ = 4'b0100;
        tick();
        DREQ = '0;
        tick();
        total++;
        if (HRQ !== 1'b1) begin bad++; $display("FAIL wd_hrq_up got=%b want=1", HRQ); end
        tick();
        total += 2;
        if (HRQ !== 1'b0) begin bad++; $display("FAIL wd_hrq_down got=%b want=0", HRQ); end
        if (chValid !== 1'b0) begin bad++; $display("FAIL wd_valid got=%b want=0", chValid); end
        HLDA = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (DACK !== 4'hF || HRQ !== 1'b0) begin
                bad++;
                $display("FAIL wd_idle%0d dack=%b hrq=%b want dack=1111 hrq=0", i, DACK, HRQ);
            end
        end
        HLDA = 1'b0;
        tick();
    endtask

    task automatic test_ctrl_disable();
        bit to;
        int e;
        do_reset();
        dreqSenseLow = 1'b1;
        DREQ = 4'b1101;
        ctrlDisable = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (HRQ !== 1'b0) begin bad++; $display("FAIL dis_hrq got=%b want=0", HRQ); end
        ctrlDisable = 1'b0;
        exp_q.push_back(1);
        wait_hrq(to);
        HLDA = 1'b1;
        wait_valid(to);
        e = exp_q.pop_front();
        total++;
        if (to || activeCh !== 2'(e)) begin bad++; $display("FAIL dis_active got=%0d want=%0d", activeCh, e); end
        ctrlDisable = 1'b1;
        tick();
        tick();
        total++;
        if (chValid !== 1'b1) begin bad++; $display("FAIL dis_no_abort got=%b want=1", chValid); end
        ctrlDisable = 1'b0;
        pulse_done();
        pulse_done();
        tick();
        total += 2;
        if (HRQ !== 1'b0) begin bad++; $display("FAIL rel_hold_hrq got=%b want=0", HRQ); end
        if (chValid !== 1'b0) begin bad++; $display("FAIL rel_hold_valid got=%b want=0", chValid); end
        DREQ = 4'b1111;
        HLDA = 1'b0;
        tick();
    endtask

    task automatic test_abort_reset();
        bit to;
        int e;
        do_reset();
        rotPriority = 1'b1;
        DREQ = 4'b0100;
        exp_q.push_back(2);
        wait_hrq(to);
        HLDA = 1'b1;
        wait_valid(to);
        e = exp_q.pop_front();
        total += 2;
        if (to || activeCh !== 2'(e)) begin bad++; $display("FAIL ab_active got=%0d want=%0d", activeCh, e); end
        if (DACK !== 4'b1011) begin bad++; $display("FAIL ab_dack got=%b want=1011", DACK); end
        HLDA = 1'b0;
        DREQ = 4'b1111;
        tick();
        total += 2;
        if (HRQ !== 1'b0 || chValid !== 1'b0) begin bad++; $display("FAIL ab_idle hrq=%b valid=%b want 0 0", HRQ, chValid); end
        if (DACK !== 4'hF) begin bad++; $display("FAIL ab_dack_off got=%b want=1111", DACK); end
        exp_q.push_back(0);
        wait_hrq(to);
        HLDA = 1'b1;
        wait_valid(to);
        e = exp_q.pop_front();
        total++;
        if (to || activeCh !== 2'(e)) begin bad++; $display("FAIL ab_last_kept got=%0d want=%0d", activeCh, e); end
        RESET = 1'b0;
        #1;
        total += 2;
        if (HRQ !== 1'b0) begin bad++; $display("FAIL rst_mid_hrq got=%b want=0", HRQ); end
        if (DACK !== 4'hF) begin bad++; $display("FAIL rst_mid_dack got=%b want=1111", DACK); end
        tick();
        RESET = 1'b1;
        HLDA = 1'b0;
        DREQ = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rotating();
        test_mask_sw();
        test_withdraw();
        test_ctrl_disable();
        test_abort_reset();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_priority_arbiter.md
DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

Interface
REQ-001 Parameter CHANNELS, default 4, number of DMA channels; taken from the shared package constant.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 DREQ  input  CHANNELS  raw channel requests, polarity set by dreqSenseLow.
REQ-005 HLDA  input  1  hold acknowledge from CPU.
REQ-006 mask  input  CHANNELS  per-channel mask bits from register file; 1 = DREQ ignored.
REQ-007 swReq  input  CHANNELS  software request bits from register file; not affected by mask.
REQ-008 ctrlDisable  input  1  command-register controller-disable bit.
REQ-009 rotPriority  input  1  command-register bit: 0 fixed, 1 rotating priority.
REQ-010 dreqSenseLow  input  1  1 = DREQ active-low.
REQ-011 dackSenseHigh  input  1  1 = DACK active-high.
REQ-012 xferDone  input  1  one-cycle pulse from timing/control: service of granted channel finished (TC, EOP_N or single-transfer end).
REQ-013 HRQ  output  1  hold request to CPU, active-high.
REQ-014 DACK  output  CHANNELS  channel acknowledges, polarity per dackSenseHigh.
REQ-015 activeCh  output  $clog2(CHANNELS)  index of granted channel; valid while chValid=1.
REQ-016 chValid  output  1  high in GRANTED state only.
REQ-017 swReqClr  output  CHANNELS  one-cycle pulse clearing swReq of the serviced channel.

Function
REQ-018 DREQ SHALL pass through one register stage (dreqQ) before use; raw DREQ never drives arbitration.
REQ-019 effReq[i] SHALL be ((dreqQ[i] XOR dreqSenseLow) AND NOT mask[i]) OR swReq[i].
REQ-020 FSM states SHALL be IDLE, HOLD_REQ, GRANTED, RELEASE.
REQ-021 IDLE: if ctrlDisable=0 and effReq nonzero, next state HOLD_REQ; HRQ registered, asserts the cycle after the request is seen.
REQ-022 HOLD_REQ: HRQ=1; if effReq becomes zero before HLDA, HRQ deasserts next cycle, go IDLE.
REQ-023 HOLD_REQ with HLDA=1 and effReq nonzero: winner selected that cycle, latched into activeCh; GRANTED entered next cycle with DACK[activeCh] active.
REQ-024 Fixed priority: channel 0 highest, CHANNELS-1 lowest.
REQ-025 Rotating priority: highest = (lastServed+1) mod CHANNELS; lastServed updates only on xferDone in GRANTED.
REQ-026 GRANTED: grant held regardless of new or higher-priority requests (no preemption); exits only on xferDone or HLDA drop.
REQ-027 xferDone in GRANTED: next cycle HRQ=0, DACK all inactive, swReqClr[activeCh] pulses one cycle, state RELEASE.
REQ-028 RELEASE: remain until HLDA=0, then IDLE; no new HRQ while HLDA=1.
REQ-029 HLDA=0 while GRANTED: abort; next cycle HRQ=0, DACK inactive, state IDLE, lastServed and swReq unchanged.
REQ-030 ctrlDisable=1 in IDLE/HOLD_REQ: go IDLE, HRQ=0; in GRANTED it does not abort the current service.
REQ-031 xferDone outside GRANTED SHALL be ignored.
REQ-032 DACK SHALL equal internal one-hot grant vector XOR {CHANNELS{~dackSenseHigh}}; inactive level follows dackSenseHigh combinationally.

Reset
REQ-033 RESET low: state IDLE, HRQ=0, grant vector 0 (DACK all inactive), activeCh=0, chValid=0, swReqClr=0, dreqQ=0, lastServed=CHANNELS-1 (channel 0 highest).
REQ-034 Reset mid-GRANTED SHALL drop HRQ and DACK immediately (asynchronously).

Structure
REQ-035 CHANNELS and the FSM state enum typedef SHALL live in dmaRegConfigPkg, imported by wildcard.
REQ-036 One sub-module, dma_rotate_pick: combinational priority picker (effReq, highest-priority index) -> winner index.
REQ-037 Top level connects to the priorityLogic modport signals of the bus interface (DREQ, HLDA in; HRQ, DACK out).

Verification
REQ-038 Fixed: DREQ=0b0110 active-high, mask=0, HLDA 2 cycles after HRQ -> activeCh=1, DACK=0b1101 (active-low sense).
REQ-039 Rotating: DREQ=0b1111 held, four xferDone/HLDA cycles -> grants in order 0,1,2,3.
REQ-040 Mask/software: DREQ=0b0001, mask=0b0001, swReq=0b1000 -> activeCh=3; on xferDone swReqClr=0b1000 for one cycle.
REQ-041 Withdraw: DREQ pulse ends before HLDA -> HRQ falls next cycle, DACK never asserts, FSM IDLE.
REQ-042 Abort/reset: HLDA dropped in GRANTED -> IDLE, lastServed unchanged; RESET low in GRANTED -> HRQ=0, DACK inactive same cycle.
